seg_word_decoder: RTL

SEG_WORD_DECODER -- requirements
Module: seg_word_decoder

---
 rtl/seg_word_decoder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/seg_word_decoder.sv
// Decodes four 7-segment digits into 2-bit codes and searches for the rotation of WORD
// that equals them, one candidate per cycle, behind a valid/ready handshake on each side.
module seg_word_decoder (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic [7:0] WORD,
    input  logic [6:0] HEX3,
    input  logic [6:0] HEX2,
    input  logic [6:0] HEX1,
    input  logic [6:0] HEX0,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] ROT,
    output logic [7:0] CODES,
    output logic       MATCH,
    output logic       SEG_ERR
);

    typedef enum logic [1:0] {StIdle, StDecode, StSearch, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  word_q;
    logic [6:0]  hex3_q, hex2_q, hex1_q, hex0_q;
    logic [1:0]  k_q;
    logic [1:0]  rot_q;
    logic        match_q;
    logic [7:0]  codes_q;
    logic        seg_err_q;

    logic [2:0]  dec3, dec2, dec1, dec0;
    logic [7:0]  dec_codes;
    logic        dec_err;
    logic        hit;

    // Returns {illegal, code}; illegal patterns decode to code 00.
    function automatic logic [2:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'b0001001: seg_decode = 3'b000;
            7'b0000110: seg_decode = 3'b001;
            7'b1111001: seg_decode = 3'b010;
            7'b1000000: seg_decode = 3'b011;
            default:    seg_decode = 3'b100;
        endcase
    endfunction

    // Rotation k places D[(p-k) mod 4] at position p: a left rotate by 2k bits.
    function automatic logic [7:0] rotate_word(input logic [7:0] w, input logic [1:0] k);
        case (k)
            2'd0:    rotate_word = w;
            2'd1:    rotate_word = {w[5:0], w[7:6]};
            2'd2:    rotate_word = {w[3:0], w[7:4]};
            default: rotate_word = {w[1:0], w[7:2]};
        endcase
    endfunction

    always_comb begin
        dec3      = seg_decode(hex3_q);
        dec2      = seg_decode(hex2_q);
        dec1      = seg_decode(hex1_q);
        dec0      = seg_decode(hex0_q);
        dec_codes = {dec3[1:0], dec2[1:0], dec1[1:0], dec0[1:0]};
        dec_err   = dec3[2] | dec2[2] | dec1[2] | dec0[2];
        hit       = (rotate_word(word_q, k_q) == codes_q);
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A segment error is resolved in the first SEARCH slot so that its result appears
    // with the same latency as a k=0 match.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (in_valid) state_d = StDecode;
            StDecode: state_d = StSearch;
            StSearch: if (seg_err_q || hit || (k_q == 2'd3)) state_d = StDone;
            StDone:   if (out_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle) && !Reset;
        out_valid = (state_q == StDone);
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            word_q    <= 8'h00;
            hex3_q    <= 7'h00;
            hex2_q    <= 7'h00;
            hex1_q    <= 7'h00;
            hex0_q    <= 7'h00;
            k_q       <= 2'd0;
            rot_q     <= 2'd0;
            match_q   <= 1'b0;
            codes_q   <= 8'h00;
            seg_err_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        word_q <= WORD;
                        hex3_q <= HEX3;
                        hex2_q <= HEX2;
                        hex1_q <= HEX1;
                        hex0_q <= HEX0;
                    end
                end
                StDecode: begin
                    codes_q   <= dec_codes;
                    seg_err_q <= dec_err;
                    k_q       <= 2'd0;
                    rot_q     <= 2'd0;
                    match_q   <= 1'b0;
                end
                StSearch: begin
                    if (!seg_err_q && hit) begin
                        rot_q   <= k_q;
                        match_q <= 1'b1;
                    end else begin
                        k_q <= k_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ROT     = rot_q;
    assign MATCH   = match_q;
    assign CODES   = codes_q;
    assign SEG_ERR = seg_err_q;

endmodule
